// File: rtl/table_fsm.sv
// Run-time programmable Mealy machine: next state and output come from a
// writable {state, x}-indexed table, with step enable, restart and change counter.
module table_fsm #(
  parameter int IN_W       = 2,
  parameter int ST_W       = 2,
  parameter int OUT_W      = 2,
  parameter int INIT_STATE = 0,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 reg_out,
  input  logic [IN_W-1:0]      x,
  output logic [OUT_W-1:0]     y,
  output logic [ST_W-1:0]      state,
  output logic [CNT_W-1:0]     chg_cnt,
  input  logic                 cfg_we,
  input  logic [ST_W+IN_W-1:0] cfg_addr,
  input  logic [ST_W-1:0]      cfg_next,
  input  logic [OUT_W-1:0]     cfg_out
);

  localparam int AW    = ST_W + IN_W;
  localparam int DEPTH = 1 << AW;
  localparam int EW    = ST_W + OUT_W;

  localparam logic [ST_W-1:0] INIT_ST = ST_W'(INIT_STATE);

  // Each entry is {next, out}. The table is flop-based because rst must clear it.
  logic [EW-1:0]    r_table [DEPTH];
  logic [ST_W-1:0]  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_yq;

  logic [AW-1:0]    w_addr;
  logic [EW-1:0]    w_entry;
  logic [ST_W-1:0]  w_tab_next;
  logic [OUT_W-1:0] w_tab_out;
  logic [ST_W-1:0]  w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [OUT_W-1:0] w_yq_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (cfg_we) begin
      r_table[cfg_addr] <= {cfg_next, cfg_out};
    end
  end

  // The lookup sees the pre-edge table, so a same-edge write affects only later steps.
  assign w_addr     = {r_state, x};
  assign w_entry    = r_table[w_addr];
  assign w_tab_next = w_entry[EW-1:OUT_W];
  assign w_tab_out  = w_entry[OUT_W-1:0];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_yq_next    = r_yq;
    if (clr) begin
      w_state_next = INIT_ST;
      w_cnt_next   = '0;
      w_yq_next    = '0;
    end else if (en) begin
      w_state_next = w_tab_next;
      w_yq_next    = w_tab_out;
      if ((w_tab_next != r_state) && !(&r_cnt)) begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= INIT_ST;
      r_cnt   <= '0;
      r_yq    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_yq    <= w_yq_next;
    end
  end

  assign y       = reg_out ? r_yq : w_tab_out;
  assign state   = r_state;
  assign chg_cnt = r_cnt;

endmodule
